// File: rtl/muldiv_if.sv
// Request/result bundle between the register-file read side, the RV32M
// multiply/divide unit and the register-file write port.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [4:0]      rdi_in;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;
    logic [4:0]      result_rdi;

    modport master (
        output start, funct3, rs1, rs2, rdi_in,
        input  busy, result_valid, result, result_rdi
    );

    modport slave (
        input  start, funct3, rs1, rs2, rdi_in,
        output busy, result_valid, result, result_rdi
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M execution unit: single-cycle multiply, 32-step restoring
// divide with sign fix-up, fast path for divide-by-zero and signed overflow.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    muldiv_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;          // funct3[1:0]; funct3[2] only steers the FSM
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [4:0]      rdi_q, rdi_d;
    logic            a_neg_q, a_neg_d;
    logic            b_neg_q, b_neg_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [4:0]      count_q, count_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [4:0]      res_rdi_q, res_rdi_d;

    logic            in_signed;
    logic            in_special;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   rem_diff;

    function automatic logic [XLEN-1:0] mul_select(
        input logic [1:0]      op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic signed [XLEN:0]     ax;
        logic signed [XLEN:0]     bx;
        logic signed [2*XLEN-1:0] p;
        ax = {((op == 2'b01) || (op == 2'b10)) & a[XLEN-1], a};
        bx = {(op == 2'b01) & b[XLEN-1], b};
        p  = ax * bx;
        return (op == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    // op[1] selects remainder, op[0] selects unsigned.
    function automatic logic [XLEN-1:0] div_fix(
        input logic [1:0]      op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b,
        input logic [XLEN-1:0] quo,
        input logic [XLEN-1:0] rem,
        input logic            a_neg,
        input logic            b_neg
    );
        logic [XLEN-1:0] q;
        logic [XLEN-1:0] r;
        if (b == '0) begin
            return op[1] ? a : ALL_ONES;
        end else if (!op[0] && (a == MIN_NEG) && (b == ALL_ONES)) begin
            return op[1] ? '0 : MIN_NEG;
        end else begin
            q = (a_neg ^ b_neg) ? ('0 - quo) : quo;
            r = a_neg ? ('0 - rem) : rem;
            return op[1] ? r : q;
        end
    endfunction

    assign in_signed  = ~bus.funct3[0];
    assign in_special = (bus.rs2 == '0) ||
                        (in_signed && (bus.rs1 == MIN_NEG) && (bus.rs2 == ALL_ONES));

    assign rem_shift = {rem_q, quo_q[XLEN-1]};
    assign rem_diff  = rem_shift - {1'b0, dvs_q};

    // State register plus all datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rdi_q     <= '0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            quo_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            count_q   <= '0;
            res_q     <= '0;
            res_rdi_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rdi_q     <= rdi_d;
            a_neg_q   <= a_neg_d;
            b_neg_q   <= b_neg_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            count_q   <= count_d;
            res_q     <= res_d;
            res_rdi_q <= res_rdi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (!bus.funct3[2])  state_d = S_MUL;
                    else if (in_special) state_d = S_FIX;
                    else                 state_d = S_DIV;
                end
            end
            S_MUL:  state_d = S_DONE;
            S_DIV:  if (count_q == 5'd31) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        rdi_d     = rdi_q;
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        count_d   = count_q;
        res_d     = res_q;
        res_rdi_d = res_rdi_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.funct3[1:0];
                    a_d     = bus.rs1;
                    b_d     = bus.rs2;
                    rdi_d   = bus.rdi_in;
                    a_neg_d = in_signed & bus.rs1[XLEN-1];
                    b_neg_d = in_signed & bus.rs2[XLEN-1];
                    quo_d   = (in_signed & bus.rs1[XLEN-1]) ? ('0 - bus.rs1) : bus.rs1;
                    dvs_d   = (in_signed & bus.rs2[XLEN-1]) ? ('0 - bus.rs2) : bus.rs2;
                    rem_d   = '0;
                    count_d = '0;
                end
            end
            S_MUL: begin
                res_d     = mul_select(op_q, a_q, b_q);
                res_rdi_d = rdi_q;
            end
            S_DIV: begin
                // Restoring step: the quotient register doubles as the dividend shifter.
                if (!rem_diff[XLEN]) begin
                    rem_d = rem_diff[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                count_d = count_q + 5'd1;
            end
            S_FIX: begin
                res_d     = div_fix(op_q, a_q, b_q, quo_q, rem_q, a_neg_q, b_neg_q);
                res_rdi_d = rdi_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.busy         = (state_q != S_IDLE);
        bus.result_valid = (state_q == S_DONE);
        bus.result       = res_q;
        bus.result_rdi   = res_rdi_q;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// ops compared against a plain-arithmetic RV32M reference.
module tb_muldiv_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (!f3[2]) return 1;
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issues one op from an idle cycle; returns first result, edges from acceptance
    // to result_valid (-1 on timeout) and the number of valid cycles seen.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rdi, output logic [31:0] res,
                         output logic [4:0] rr, output int lat, output int pulses);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.rs1    = a;
        bus.rs2    = b;
        bus.rdi_in = rdi;
        tick();
        bus.start  = 1'b0;
        bus.funct3 = 3'($urandom);
        bus.rs1    = $urandom;
        bus.rs2    = $urandom;
        bus.rdi_in = 5'($urandom);
        lat = -1;
        pulses = 0;
        res = '0;
        rr = '0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bus.result_valid) begin
                lat = k;
                pulses = 1;
                res = bus.result;
                rr = bus.result_rdi;
                break;
            end
        end
        tick();
        if (bus.result_valid) pulses++;
    endtask

    task automatic test_reset;
        logic [31:0] res;
        logic [4:0]  rr;
        int          lat;
        int          pulses;
        int          seen;
        rst_n = 1'b0;
        tick();
        tick();
        checks += 4;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.result_valid); end
        if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", bus.result); end
        if (bus.result_rdi !== 5'h0) begin errors++; $display("FAIL reset_rdi got %0d want 0", bus.result_rdi); end
        rst_n = 1'b1;
        tick();
        bus.start = 1'b1; bus.funct3 = 3'd4; bus.rs1 = 32'd1000; bus.rs2 = 32'd3; bus.rdi_in = 5'd7;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks += 2;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %0b want 0", bus.busy); end
        if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %0b want 0", bus.result_valid); end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.result_valid) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midreset_no_result got %0d valids want 0", seen); end
        do_op(3'd0, 32'd3, 32'd4, 5'd2, res, rr, lat, pulses);
        checks += 2;
        if (res !== 32'd12) begin errors++; $display("FAIL post_reset_mul got %h want %h", res, 32'd12); end
        if (lat != 1) begin errors++; $display("FAIL post_reset_mul_lat got %0d want 1", lat); end
    endtask

    task automatic test_mul;
        logic [31:0] res;
        logic [4:0]  rr;
        int          lat;
        int          pulses;
        logic [31:0] exp_v [4];
        exp_v[0] = 32'hFFFF_FFFE;
        exp_v[1] = 32'hFFFF_FFFF;
        exp_v[2] = 32'hFFFF_FFFF;
        exp_v[3] = 32'h0000_0001;
        for (int i = 0; i < 4; i++) begin
            do_op(3'(i), 32'hFFFF_FFFF, 32'd2, 5'd5, res, rr, lat, pulses);
            checks += 4;
            if (res !== exp_v[i]) begin errors++; $display("FAIL mul_f%0d_result got %h want %h", i, res, exp_v[i]); end
            if (rr !== 5'd5) begin errors++; $display("FAIL mul_f%0d_rdi got %0d want 5", i, rr); end
            if (lat != 1) begin errors++; $display("FAIL mul_f%0d_latency got %0d want 1", i, lat); end
            if (pulses != 1) begin errors++; $display("FAIL mul_f%0d_pulses got %0d want 1", i, pulses); end
        end
    endtask

    task automatic test_div;
        logic [31:0] res;
        logic [4:0]  rr;
        int          lat;
        int          pulses;
        logic [2:0]  f3v [4];
        logic [31:0] av  [4];
        logic [31:0] bv  [4];
        logic [31:0] ev  [4];
        f3v[0] = 3'd4; av[0] = 32'hFFFF_FFF9; bv[0] = 32'd2; ev[0] = 32'hFFFF_FFFD;
        f3v[1] = 3'd6; av[1] = 32'hFFFF_FFF9; bv[1] = 32'd2; ev[1] = 32'hFFFF_FFFF;
        f3v[2] = 3'd5; av[2] = 32'd100;       bv[2] = 32'd7; ev[2] = 32'd14;
        f3v[3] = 3'd7; av[3] = 32'd100;       bv[3] = 32'd7; ev[3] = 32'd2;
        for (int i = 0; i < 4; i++) begin
            do_op(f3v[i], av[i], bv[i], 5'(i + 10), res, rr, lat, pulses);
            checks += 3;
            if (res !== ev[i]) begin errors++; $display("FAIL div_%0d_result got %h want %h", i, res, ev[i]); end
            if (rr !== 5'(i + 10)) begin errors++; $display("FAIL div_%0d_rdi got %0d want %0d", i, rr, i + 10); end
            if (lat != 33) begin errors++; $display("FAIL div_%0d_latency got %0d want 33", i, lat); end
        end
    endtask

    task automatic test_special;
        logic [31:0] res;
        logic [4:0]  rr;
        int          lat;
        int          pulses;
        logic [2:0]  f3v [4];
        logic [31:0] av  [4];
        logic [31:0] bv  [4];
        logic [31:0] ev  [4];
        f3v[0] = 3'd5; av[0] = 32'h0001_2345; bv[0] = 32'h0;         ev[0] = 32'hFFFF_FFFF;
        f3v[1] = 3'd6; av[1] = 32'h0001_2345; bv[1] = 32'h0;         ev[1] = 32'h0001_2345;
        f3v[2] = 3'd4; av[2] = 32'h8000_0000; bv[2] = 32'hFFFF_FFFF; ev[2] = 32'h8000_0000;
        f3v[3] = 3'd6; av[3] = 32'h8000_0000; bv[3] = 32'hFFFF_FFFF; ev[3] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            do_op(f3v[i], av[i], bv[i], 5'd31, res, rr, lat, pulses);
            checks += 2;
            if (res !== ev[i]) begin errors++; $display("FAIL special_%0d_result got %h want %h", i, res, ev[i]); end
            if (lat != 1) begin errors++; $display("FAIL special_%0d_latency got %0d want 1", i, lat); end
        end
    endtask

    task automatic test_start_held;
        int seen;
        int lat;
        bus.start = 1'b1; bus.funct3 = 3'd5; bus.rs1 = 32'd100; bus.rs2 = 32'd7; bus.rdi_in = 5'd3;
        tick();
        bus.funct3 = 3'd0; bus.rs1 = 32'd5; bus.rs2 = 32'd6; bus.rdi_in = 5'd9;
        seen = 0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bus.result_valid) begin
                seen++;
                if (lat < 0) begin
                    lat = k;
                    checks += 2;
                    if (bus.result !== 32'd14) begin errors++; $display("FAIL held_first_result got %h want %h", bus.result, 32'd14); end
                    if (bus.result_rdi !== 5'd3) begin errors++; $display("FAIL held_first_rdi got %0d want 3", bus.result_rdi); end
                end
            end
            if (lat > 0) break;
        end
        checks++;
        if (lat != 33) begin errors++; $display("FAIL held_latency got %0d want 33", lat); end
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL held_idle_after_done got busy %0b want 0", bus.busy); end
        tick();
        bus.start = 1'b0;
        tick();
        checks += 3;
        if (bus.result_valid !== 1'b1) begin errors++; $display("FAIL held_second_valid got %0b want 1", bus.result_valid); end
        if (bus.result !== 32'd30) begin errors++; $display("FAIL held_second_result got %h want %h", bus.result, 32'd30); end
        if (bus.result_rdi !== 5'd9) begin errors++; $display("FAIL held_second_rdi got %0d want 9", bus.result_rdi); end
        tick();
    endtask

    function automatic logic [31:0] pick_operand(input bit allow_zero);
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0: return allow_zero ? 32'h0 : 32'h1;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random;
        logic [31:0] res;
        logic [4:0]  rr;
        int          lat;
        int          pulses;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rdi;
        logic [31:0] exp_r;
        int          exp_l;
        for (int n = 0; n < 1000; n++) begin
            f3  = 3'($urandom);
            a   = pick_operand(1'b1);
            b   = pick_operand(1'b1);
            rdi = 5'($urandom);
            exp_r = ref_model(f3, a, b);
            exp_l = ref_latency(f3, a, b);
            do_op(f3, a, b, rdi, res, rr, lat, pulses);
            checks++;
            if (res !== exp_r || rr !== rdi || lat != exp_l || pulses != 1) begin
                errors++;
                $display("FAIL rand_%0d f3=%0d a=%h b=%h got res=%h rdi=%0d lat=%0d pulses=%0d want res=%h rdi=%0d lat=%0d pulses=1",
                         n, f3, a, b, res, rr, lat, pulses, exp_r, rdi, exp_l);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.funct3 = 3'd0;
        bus.rs1 = '0;
        bus.rs2 = '0;
        bus.rdi_in = '0;
        tick();
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_start_held();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
